// File: rtl/n101_uartrx_cfg_if.sv
// Received-character bundle from the n101 UART RX core to its register/FIFO wrapper.
// master = receiver core (producer), slave = wrapper (consumer).
interface n101_uartrx_cfg_if #(
    parameter int unsigned DATA_W = 8
);
    logic              valid;
    logic [DATA_W-1:0] bits;
    logic              frame_err;
    logic              parity_err;
    logic              brk;

    modport master (output valid, bits, frame_err, parity_err, brk);
    modport slave  (input  valid, bits, frame_err, parity_err, brk);
endinterface

// File: rtl/n101_uartrx_cfg.sv
// n101 run-time configurable UART receiver: 5..DATA_W data bits, 2-of-3 oversampled vote, 1/2 stop bits.
// Parity (PARITY state, parity_err, parity term of break) exists only when N101_UARTRX_PARITY_EN is defined.
module n101_uartrx_cfg #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OVS_LOG2 = 4,
    parameter int unsigned DIV_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_en,
    input  logic              io_in,
    input  logic [DIV_W-1:0]  io_div,
    input  logic [3:0]        io_nbits,
    input  logic              io_stop2,
    input  logic [1:0]        io_parity,
    n101_uartrx_cfg_if.master io_out
);
    localparam int unsigned         PW     = DIV_W - OVS_LOG2;
    localparam int unsigned         OVS    = 1 << OVS_LOG2;
    localparam logic [OVS_LOG2-1:0] T_HALF = OVS_LOG2'(OVS / 2);
    localparam logic [OVS_LOG2-1:0] T_FULL = OVS_LOG2'(OVS - 1);
    localparam logic [3:0]          NB_MAX = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [OVS_LOG2-1:0] timer_q, timer_d;
    logic [2:0]          samp_q, samp_d;
    logic [1:0]          deb_q, deb_d;
    logic                hold_q, hold_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic                ferr_q, ferr_d;
    logic                perr_q, perr_d;
    logic                pzero_q, pzero_d;
    logic                brk_q, brk_d;
    logic                ovalid_q, ovalid_d;
    logic [DATA_W-1:0]   obits_q, obits_d;
    logic                oferr_q, oferr_d;
    logic                operr_q, operr_d;
    logic                obrk_q, obrk_d;

    logic       busy, tick, expire, start, finish;
    logic       vote, par_en, par_odd;
    logic [3:0] nb;
    logic       div_unused;

    assign div_unused = ^io_div[OVS_LOG2-1:0];
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign nb   = (io_nbits < 4'd5 || io_nbits > NB_MAX) ? NB_MAX : io_nbits;

`ifdef N101_UARTRX_PARITY_EN
    assign par_en  = (io_parity == 2'd1) || (io_parity == 2'd2);
    assign par_odd = (io_parity == 2'd2);
`else
    logic parity_unused;
    assign parity_unused = ^io_parity;
    assign par_en  = 1'b0;
    assign par_odd = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            timer_q  <= '0;
            samp_q   <= '0;
            deb_q    <= '0;
            hold_q   <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            pzero_q  <= 1'b0;
            brk_q    <= 1'b0;
            ovalid_q <= 1'b0;
            obits_q  <= '0;
            oferr_q  <= 1'b0;
            operr_q  <= 1'b0;
            obrk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            samp_q   <= samp_d;
            deb_q    <= deb_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            pzero_q  <= pzero_d;
            brk_q    <= brk_d;
            ovalid_q <= ovalid_d;
            obits_q  <= obits_d;
            oferr_q  <= oferr_d;
            operr_q  <= operr_d;
            obrk_q   <= obrk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start)  state_d = S_START;
            S_START:  if (expire) state_d = vote ? S_IDLE : S_DATA;
            S_DATA:   if (expire && cnt_q <= 4'd1) state_d = par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (expire) state_d = S_STOP1;
            S_STOP1:  if (expire) state_d = io_stop2 ? S_STOP2 : S_IDLE;
            S_STOP2:  if (expire) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (!io_en) state_d = S_IDLE;
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        tick   = busy && (presc_q == '0);
        expire = tick && (timer_q == '0);
        start  = io_en && (state_q == S_IDLE) && !hold_q && !io_in && (deb_q == 2'd3);
        finish = io_en && expire && (((state_q == S_STOP1) && !io_stop2) || (state_q == S_STOP2));
    end

    always_comb begin
        presc_d  = presc_q;
        timer_d  = timer_q;
        samp_d   = samp_q;
        deb_d    = deb_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        pzero_d  = pzero_q;
        brk_d    = brk_q;
        ovalid_d = finish;
        obits_d  = obits_q;
        oferr_d  = oferr_q;
        operr_d  = operr_q;
        obrk_d   = obrk_q;

        if (start || tick) presc_d = io_div[DIV_W-1:OVS_LOG2];
        else if (busy)     presc_d = presc_q - PW'(1);

        if (start)       timer_d = T_HALF;
        else if (expire) timer_d = T_FULL;
        else if (tick)   timer_d = timer_q - OVS_LOG2'(1);

        if (tick) samp_d = {samp_q[1:0], io_in};

        // After a frame ends the line must be seen high before the debounce may count,
        // so a held break line yields exactly one character.
        if (state_q == S_IDLE) begin
            if (hold_q) begin
                deb_d = '0;
                if (io_in) hold_d = 1'b0;
            end else if (!io_in) begin
                deb_d = (deb_q == 2'd3) ? 2'd0 : deb_q + 2'd1;
            end else if (deb_q != 2'd0) begin
                deb_d = deb_q - 2'd1;
            end
        end
        if (finish) hold_d = 1'b1;
        if (!io_en) deb_d = '0;

        if (expire) begin
            unique case (state_q)
                S_START: if (!vote) begin
                    cnt_d   = nb;
                    sh_d    = '0;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                    pzero_d = 1'b1;
                    brk_d   = 1'b0;
                end
                S_DATA: begin
                    sh_d = sh_q >> 1;
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (i == 32'(nb) - 32'd1) sh_d[i] = vote;
                    end
                    cnt_d = cnt_q - 4'd1;
                end
                S_PARITY: begin
                    perr_d  = ((^sh_q) ^ vote) != par_odd;
                    pzero_d = !vote;
                end
                S_STOP1: begin
                    ferr_d = ferr_q | !vote;
                    brk_d  = (sh_q == '0) && pzero_q && !vote;
                end
                S_STOP2: ferr_d = ferr_q | !vote;
                default: ;
            endcase
        end

        if (finish) begin
            obits_d = sh_q;
            oferr_d = ferr_d;
            operr_d = perr_q;
            obrk_d  = brk_d;
        end
    end

    assign io_out.valid      = ovalid_q;
    assign io_out.bits       = obits_q;
    assign io_out.frame_err  = oferr_q;
    assign io_out.parity_err = operr_q;
    assign io_out.brk        = obrk_q;
endmodule

// File: tb/tb_n101_uartrx_cfg.sv
// Directed bench for n101_uartrx_cfg: a frame-level model predicts each character, its flags and its
// arrival window; a negedge monitor checks every output cycle against it.
module tb_n101_uartrx_cfg;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned OVS_LOG2 = 4;
    localparam int unsigned DIV_W    = 16;
`ifdef N101_UARTRX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_en;
    logic              io_in;
    logic [DIV_W-1:0]  io_div;
    logic [3:0]        io_nbits;
    logic              io_stop2;
    logic [1:0]        io_parity;

    n101_uartrx_cfg_if #(.DATA_W(DATA_W)) rx_if ();

    n101_uartrx_cfg #(.DATA_W(DATA_W), .OVS_LOG2(OVS_LOG2), .DIV_W(DIV_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .io_en     (io_en),
        .io_in     (io_in),
        .io_div    (io_div),
        .io_nbits  (io_nbits),
        .io_stop2  (io_stop2),
        .io_parity (io_parity),
        .io_out    (rx_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  bits;
        logic        ferr;
        logic        perr;
        logic        brk;
        int unsigned t_lo;
        int unsigned t_hi;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned bit_clk  = 32;
    logic        rst_d    = 1'b1;
    bit          run      = 1'b0;
    logic [10:0] held     = '0;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_d <= reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Character expected from the line levels the bench drives.
    function automatic exp_t make_exp(input logic [7:0] data, input logic [3:0] ncfg, input logic [1:0] par,
                                      input logic pbit, input logic s1, input logic s2en, input logic s2,
                                      input int unsigned t0);
        exp_t        e;
        int unsigned n;
        int unsigned last;
        bit          pe;
        bit          odd;
        logic [7:0]  d;
        n      = (ncfg < 5 || ncfg > DATA_W) ? DATA_W : int'(ncfg);
        pe     = PAR_BUILD && (par == 2'd1 || par == 2'd2);
        odd    = (par == 2'd2);
        d      = data & 8'((1 << n) - 1);
        e.bits = d;
        e.ferr = !s1 || (s2en && !s2);
        e.perr = pe && (((^d) ^ pbit) != odd);
        e.brk  = (d == 8'd0) && (!pe || !pbit) && !s1;
        last   = 1 + n + (pe ? 1 : 0) + (s2en ? 1 : 0);
        e.t_lo = t0 + last * bit_clk + bit_clk / 2;
        e.t_hi = t0 + (last + 1) * bit_clk - 1;
        return e;
    endfunction

    always @(negedge clock) begin
        if (run) begin
            if (rst_d) begin
                chk("reset_clears_outputs",
                    32'({rx_if.valid, rx_if.bits, rx_if.frame_err, rx_if.parity_err, rx_if.brk}), 32'd0);
                held = '0;
            end else if (rx_if.valid === 1'b1) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid=1 bits=0x%0h, expected no character (cycle %0d)",
                             rx_if.bits, cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("char_bits", 32'(rx_if.bits), 32'(e.bits));
                    chk("char_flags_fpb", 32'({rx_if.frame_err, rx_if.parity_err, rx_if.brk}),
                        32'({e.ferr, e.perr, e.brk}));
                    n_checks++;
                    if (cyc < e.t_lo || cyc > e.t_hi) begin
                        n_fail++;
                        $display("FAIL char_latency: got valid at cycle %0d, expected %0d..%0d", cyc, e.t_lo, e.t_hi);
                    end
                    held = {e.bits, e.ferr, e.perr, e.brk};
                end
            end else begin
                chk("outputs_hold", 32'({rx_if.bits, rx_if.frame_err, rx_if.parity_err, rx_if.brk}), 32'(held));
            end
        end
    end

    task automatic clk(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        io_in = v;
        clk(bit_clk);
    endtask

    task automatic idle(input int unsigned nbit);
        io_in = 1'b1;
        clk(nbit * bit_clk);
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned k = 0;
        while (expq.size() != 0 && k < budget) begin
            clk(1);
            k++;
        end
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL char_timeout: got %0d characters pending, expected 0 within %0d cycles", expq.size(), budget);
            expq.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic s1, input logic s2);
        int unsigned n;
        bit          pe;
        n  = (io_nbits < 5 || io_nbits > DATA_W) ? DATA_W : int'(io_nbits);
        pe = PAR_BUILD && (io_parity == 2'd1 || io_parity == 2'd2);
        expq.push_back(make_exp(data, io_nbits, io_parity, pbit, s1, io_stop2, s2, cyc));
        drive_bit(1'b0);
        for (int unsigned i = 0; i < n; i++) drive_bit(data[i]);
        if (pe) drive_bit(pbit);
        drive_bit(s1);
        if (io_stop2) drive_bit(s2);
        io_in = 1'b1;
        wait_drain(4 * bit_clk);
        idle(2);
    endtask

    // Start plus kbits data bits, then line high and a one-cycle reset (kind 0) or io_en drop (kind 1).
    task automatic abort_frame(input logic [7:0] data, input int unsigned kbits, input int unsigned kind);
        drive_bit(1'b0);
        for (int unsigned i = 0; i < kbits; i++) drive_bit(data[i]);
        io_in = 1'b1;
        clk(bit_clk / 2);
        if (kind == 0) reset = 1'b1;
        else           io_en = 1'b0;
        clk(1);
        reset = 1'b0;
        io_en = 1'b1;
        idle(12);
    endtask

    initial begin
        io_en     = 1'b1;
        io_in     = 1'b1;
        io_div    = 16'h0010;
        io_nbits  = 4'd8;
        io_stop2  = 1'b0;
        io_parity = 2'd0;
        reset     = 1'b1;
        clk(3);
        chk("reset_valid", 32'(rx_if.valid), 32'd0);
        chk("reset_bits", 32'(rx_if.bits), 32'd0);
        chk("reset_flags", 32'({rx_if.frame_err, rx_if.parity_err, rx_if.brk}), 32'd0);
        reset = 1'b0;
        run   = 1'b1;
        idle(2);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        chk("lit_a5_bits", 32'(rx_if.bits), 32'h0000_00A5);
        chk("lit_a5_flags", 32'({rx_if.frame_err, rx_if.parity_err, rx_if.brk}), 32'd0);

        io_nbits = 4'd5;
        io_stop2 = 1'b1;
        send_frame(8'h13, 1'b0, 1'b1, 1'b1);
        chk("lit_5n2_bits", 32'(rx_if.bits), 32'h0000_0013);
        chk("lit_5n2_ferr", 32'(rx_if.frame_err), 32'd0);
        send_frame(8'h13, 1'b0, 1'b1, 1'b0);
        chk("lit_5n2_stop2_low_bits", 32'(rx_if.bits), 32'h0000_0013);
        chk("lit_5n2_stop2_low_ferr", 32'(rx_if.frame_err), 32'd1);

        io_nbits  = 4'd8;
        io_stop2  = 1'b0;
        io_parity = 2'd1;
`ifdef N101_UARTRX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        chk("lit_even_ok_perr", 32'(rx_if.parity_err), 32'd0);
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        chk("lit_even_bad_perr", 32'(rx_if.parity_err), 32'd1);
        io_parity = 2'd2;
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        chk("lit_odd_ok_perr", 32'(rx_if.parity_err), 32'd0);
`else
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        chk("lit_parity_ignored_bits", 32'(rx_if.bits), 32'h0000_0007);
        chk("lit_parity_ignored_perr", 32'(rx_if.parity_err), 32'd0);
`endif
        io_parity = 2'd0;

        // Held break: one character only, nothing more until the line returns high.
        expq.push_back(make_exp(8'h00, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, cyc));
        io_in = 1'b0;
        clk(15 * bit_clk);
        io_in = 1'b1;
        wait_drain(4);
        idle(3);
        chk("lit_break_bits", 32'(rx_if.bits), 32'd0);
        chk("lit_break_flags_fpb", 32'({rx_if.frame_err, rx_if.parity_err, rx_if.brk}), 32'b101);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);

        io_in = 1'b0;
        clk(8);
        idle(12);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);

        abort_frame(8'h3C, 3, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        chk("lit_after_reset_bits", 32'(rx_if.bits), 32'h0000_003C);
        abort_frame(8'h3C, 3, 1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        chk("lit_after_en_drop_bits", 32'(rx_if.bits), 32'h0000_003C);

        io_nbits = 4'd15;
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        chk("lit_nbits_oor_bits", 32'(rx_if.bits), 32'h0000_0081);
        io_nbits = 4'd8;

        io_div = 16'h001F;
        send_frame(8'h69, 1'b0, 1'b1, 1'b1);
        chk("lit_div_lowbits_bits", 32'(rx_if.bits), 32'h0000_0069);

        io_div  = 16'h0000;
        bit_clk = 16;
        idle(2);
        send_frame(8'h96, 1'b0, 1'b1, 1'b1);
        chk("lit_div0_bits", 32'(rx_if.bits), 32'h0000_0096);

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, expected completion within 300000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
